// File: rtl/grid_stream_reader_pkg.sv
// Shared types and default sizing for the grid stream reader.
package grid_stream_reader_pkg;

  // Default sizing; the top-level parameters override these per instance.
  localparam int DATA_WIDTH_DEF    = 16;
  localparam int ADDRESS_WIDTH_DEF = 12;
  localparam int GRID_W_DEF        = 50;
  localparam int GRID_H_DEF        = 50;

  // Width of the row and column tags carried alongside each word.
  localparam int TAG_WIDTH = 8;

  // Scan controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/grid_stream_reader_fifo2_reg.sv
// Two-entry register FIFO.
// The head entry sits in a register and drives the consumer directly.
// The caller's credit logic guarantees that nothing is pushed into a full FIFO
// unless a pop happens in the same cycle.
module fifo2_reg #(
  parameter int ENTRY_WIDTH = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [ENTRY_WIDTH-1:0] push_entry,
  input  logic                   pop,
  output logic [1:0]             occ,
  output logic                   head_valid,
  output logic [ENTRY_WIDTH-1:0] head
);

  logic [ENTRY_WIDTH-1:0] head_q, head_d;
  logic [ENTRY_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]             occ_q, occ_d;
  logic                   valid_q, valid_d;
  logic                   pop_s;

  // Next-state of the storage slots and occupancy for every push/pop combination.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    pop_s  = pop & valid_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_d = push_entry;
          occ_d  = 2'd1;
        end else begin
          occ_d  = 2'd0;
        end
      end
      2'd1: begin
        if (push && pop_s) begin
          head_d = push_entry;
          occ_d  = 2'd1;
        end else if (push) begin
          tail_d = push_entry;
          occ_d  = 2'd2;
        end else if (pop_s) begin
          occ_d  = 2'd0;
        end else begin
          occ_d  = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          head_d = tail_q;
          if (push) begin
            tail_d = push_entry;
            occ_d  = 2'd2;
          end else begin
            occ_d  = 2'd1;
          end
        end else begin
          occ_d  = 2'd2;
        end
      end
      default: begin
        occ_d = 2'd0;
      end
    endcase
    valid_d = (occ_d != 2'd0);
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= {ENTRY_WIDTH{1'b0}};
      tail_q  <= {ENTRY_WIDTH{1'b0}};
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
    end
  end

  assign occ        = occ_q;
  assign head_valid = valid_q;
  assign head       = head_q;

endmodule

// File: rtl/grid_stream_reader.sv
// Scans the grid RAM in row-major order and streams the words out with
// row, column and last tags.
// The RAM read latency is hidden by an issue-credit scheme feeding a two-entry FIFO.
module grid_stream_reader import grid_stream_reader_pkg::*; #(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int GRID_W        = GRID_W_DEF,
  parameter int GRID_H        = GRID_H_DEF,
  parameter int BASE_ADDR     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_write_en,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_out,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [7:0]               out_row,
  output logic [7:0]               out_col,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int ENTRY_WIDTH = 1 + 2 * TAG_WIDTH + DATA_WIDTH;
  localparam int TAG_BITS    = 1 + 2 * TAG_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] FIRST_ADDR = ADDRESS_WIDTH'(BASE_ADDR);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR  = ADDRESS_WIDTH'(BASE_ADDR + GRID_W * GRID_H - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE   = ADDRESS_WIDTH'(1);
  localparam logic [7:0]               COL_LAST   = 8'(GRID_W - 1);

  state_e                   state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]               row_q, row_d;
  logic [7:0]               col_q, col_d;
  logic                     inflight_q, inflight_d;
  logic [TAG_BITS-1:0]      itag_q, itag_d;

  logic [1:0]             occ_s;
  logic                   head_valid_s;
  logic [ENTRY_WIDTH-1:0] head_s;
  logic                   pop_s;
  logic                   issue_s;
  logic                   issue_last_s;

  assign pop_s        = head_valid_s & out_ready;
  assign issue_last_s = (addr_q == LAST_ADDR);
  // Credit check: words already buffered or in flight, less the one leaving now, must leave room.
  assign issue_s      = (state_q == ST_RUN) &&
                        (({1'b0, occ_s} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s}));

  // Scan FSM, address/index counters and issue bookkeeping.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    row_d      = row_q;
    col_d      = col_q;
    inflight_d = 1'b0;
    itag_d     = itag_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The done cycle still belongs to the scan that just finished, so start is not taken then.
        if (start && !done_q) begin
          state_d = ST_RUN;
          addr_d  = FIRST_ADDR;
          row_d   = 8'd0;
          col_d   = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_s) begin
          inflight_d = 1'b1;
          itag_d     = {issue_last_s, row_q, col_q};
          if (issue_last_s) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_ONE;
            if (col_q == COL_LAST) begin
              col_d = 8'd0;
              row_d = row_q + 8'd1;
            end else begin
              col_d = col_q + 8'd1;
            end
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pop_s && head_s[ENTRY_WIDTH-1]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= FIRST_ADDR;
      row_q      <= 8'd0;
      col_q      <= 8'd0;
      inflight_q <= 1'b0;
      itag_q     <= {TAG_BITS{1'b0}};
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      inflight_q <= inflight_d;
      itag_q     <= itag_d;
    end
  end

  // Word returning from the RAM joins its tags one cycle after issue.
  fifo2_reg #(
    .ENTRY_WIDTH(ENTRY_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_q),
    .push_entry ({itag_q, mem_data_out}),
    .pop        (pop_s),
    .occ        (occ_s),
    .head_valid (head_valid_s),
    .head       (head_s)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_addr     = addr_q;
  assign mem_write_en = 1'b0;
  assign mem_data_in  = {DATA_WIDTH{1'b0}};
  assign out_valid    = head_valid_s;
  assign out_data     = head_s[DATA_WIDTH-1:0];
  assign out_col      = head_s[DATA_WIDTH+TAG_WIDTH-1:DATA_WIDTH];
  assign out_row      = head_s[DATA_WIDTH+2*TAG_WIDTH-1:DATA_WIDTH+TAG_WIDTH];
  assign out_last     = head_s[ENTRY_WIDTH-1];

endmodule
